// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//
// Buffers whole NDN interest/data packets from the forwarding core in a small
// FIFO and hands them to the SPI serializer one at a time. The serializer has
// no busy output, so each issue is followed by a spacing interval equal to the
// serial frame length of the packet type plus GAP_CYCLES idle cycles. No new
// packet is issued before that interval has elapsed.
//
// Optional feature: define SPI_TX_STATS_EN to add the per-type issue counters
// interest_sent_count / data_sent_count.
//
// Ports:
//   clk                     clock, shared with the serializer
//   rst                     asynchronous, active-high reset
//   in_valid / in_ready     packet handshake from the core (push on both high)
//   in_meta                 bit6 = 1 interest / 0 data, bits5:0 prefix length
//   in_prefix               64-bit content prefix
//   in_data                 256-bit payload (stored as-is for interests too)
//   TX_valid                one-cycle issue pulse to the serializer
//   packet_meta_data_input  issued meta byte (held until the next issue)
//   packet_prefix_input     issued prefix (held until the next issue)
//   packet_data_input       issued payload (held until the next issue)
//   busy                    high from the issue cycle until spacing expires
//   fifo_count              current FIFO occupancy
//   interest_sent_count     (SPI_TX_STATS_EN) interests issued, wraps at 16 bits
//   data_sent_count         (SPI_TX_STATS_EN) data packets issued, wraps at 16 bits

module spi_tx_scheduler #(
    parameter int DEPTH                 = 4,
    parameter int GAP_CYCLES            = 2,
    parameter int INTEREST_FRAME_CYCLES = 73,
    parameter int DATA_FRAME_CYCLES     = 329
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_meta,
    input  logic [63:0]                in_prefix,
    input  logic [255:0]               in_data,
    output logic                       TX_valid,
    output logic [7:0]                 packet_meta_data_input,
    output logic [63:0]                packet_prefix_input,
    output logic [255:0]               packet_data_input,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef SPI_TX_STATS_EN
    ,
    output logic [15:0]                interest_sent_count,
    output logic [15:0]                data_sent_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SPC_W = $clog2(DATA_FRAME_CYCLES + GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // The counter is loaded with S-1 on the issue edge and reaches zero just
    // before edge issue+S, which is the first edge allowed to issue again.
    function automatic logic [SPC_W-1:0] spacing_load(input logic is_interest);
        if (is_interest) begin
            return SPC_W'(INTEREST_FRAME_CYCLES + GAP_CYCLES - 1);
        end
        return SPC_W'(DATA_FRAME_CYCLES + GAP_CYCLES - 1);
    endfunction

    // FIFO storage (data only, never reset)
    logic [7:0]   meta_mem   [DEPTH];
    logic [63:0]  prefix_mem [DEPTH];
    logic [255:0] data_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic issue;

    logic [7:0]   head_meta;
    logic [63:0]  head_prefix;
    logic [255:0] head_data;

    state_t           state;
    state_t           state_next;
    logic [SPC_W-1:0] spc;
    logic [SPC_W-1:0] spc_next;
    logic             busy_next;

    // in_ready depends only on the current occupancy, so a full FIFO refuses
    // a push even in a cycle where it also pops.
    assign in_ready = ~rst & (fifo_count < DEPTH_CNT);
    assign push     = in_valid & in_ready;

    assign head_meta   = meta_mem[rd_ptr];
    assign head_prefix = prefix_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            meta_mem[wr_ptr]   <= in_meta;
            prefix_mem[wr_ptr] <= in_prefix;
            data_mem[wr_ptr]   <= in_data;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue / spacing control. fifo_count is the registered occupancy, so a
    // push on the same edge is only seen on the following edge.
    always_comb begin
        state_next = state;
        spc_next   = spc;
        busy_next  = busy;
        issue      = 1'b0;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (fifo_count != '0) begin
                    issue      = 1'b1;
                    spc_next   = spacing_load(head_meta[6]);
                    busy_next  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (spc == '0) begin
                    // Spacing has expired: issue back-to-back if something is
                    // queued, otherwise release busy and go idle.
                    if (fifo_count != '0) begin
                        issue     = 1'b1;
                        spc_next  = spacing_load(head_meta[6]);
                        busy_next = 1'b1;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end else begin
                    spc_next = spc - SPC_W'(1);
                end
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            spc                    <= '0;
            busy                   <= 1'b0;
            TX_valid               <= 1'b0;
            packet_meta_data_input <= '0;
            packet_prefix_input    <= '0;
            packet_data_input      <= '0;
        end else begin
            state    <= state_next;
            spc      <= spc_next;
            busy     <= busy_next;
            TX_valid <= issue;
            // Outputs hold between issues so the serializer sees stable fields.
            if (issue) begin
                packet_meta_data_input <= head_meta;
                packet_prefix_input    <= head_prefix;
                packet_data_input      <= head_data;
            end
        end
    end

`ifdef SPI_TX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interest_sent_count <= '0;
            data_sent_count     <= '0;
        end else if (issue) begin
            if (head_meta[6]) begin
                interest_sent_count <= interest_sent_count + 16'd1;
            end else begin
                data_sent_count <= data_sent_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Sits directly upstream of the SPI serializer's transmit side, between the NDN forwarding core and the serializer.
- Accepts whole interest/data packets from the core over a valid/ready handshake and queues them in a small FIFO.
- Issues each packet to the serializer as a one-cycle TX_valid pulse with stable fields.
- The serializer has no busy output, so this block enforces frame spacing. It does this by counting the serial frame length for each packet type.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- GAP_CYCLES, 2, extra idle (mosi high) cycles between frames.
- INTEREST_FRAME_CYCLES, 73, serial cycles for an interest frame (1 start + 8 meta + 64 prefix).
- DATA_FRAME_CYCLES, 329, serial cycles for a data frame (73 + 256 data).

Ports:
- clk  in  1  clock, shared with the serializer.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  core offers a packet.
- in_ready  out  1  FIFO can accept; push occurs when in_valid & in_ready at a posedge.
- in_meta  in  8  bit7 = don't-care, bit6 = 1 interest / 0 data, bits5:0 = prefix length.
- in_prefix  in  64  content prefix.
- in_data  in  256  payload; ignored for interests but stored as-is.
- TX_valid  out  1  one-cycle issue pulse to the serializer.
- packet_meta_data_input  out  8  issued meta byte.
- packet_prefix_input  out  64  issued prefix.
- packet_data_input  out  256  issued payload.
- busy  out  1  high from the issue cycle until spacing expires.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:

Reset:
- On rst: FIFO empty, fifo_count = 0, TX_valid = 0, all packet_*_input outputs = 0, busy = 0, state = IDLE.
- in_ready = 0 while rst is high. After release, in_ready = (fifo_count < DEPTH), combinational from occupancy.

FIFO:
- Pointers wrap modulo DEPTH.
- When full, a push is refused even if a pop happens in the same cycle (in_ready depends only on the current count).
- A simultaneous push and pop while not full leaves the count unchanged.
- Entries are issued in FIFO order.

State machine (IDLE, WAIT):
- IDLE, fifo_count > 0 at a posedge:
  - Register TX_valid = 1.
  - Register the outputs from the FIFO head and pop it.
  - Compute S = (head meta[6] ? INTEREST_FRAME_CYCLES : DATA_FRAME_CYCLES) + GAP_CYCLES.
  - Load the spacing counter, set busy = 1, go to WAIT.
- IDLE, FIFO empty: TX_valid = 0, outputs hold their last values.
- WAIT:
  - TX_valid = 0 and busy = 1.
  - The counter decrements each cycle. Once S cycles have elapsed since the issue edge, the block may issue again.
  - The next TX_valid rises exactly S cycles after the previous one if an entry is waiting, and later otherwise.
  - busy drops in the cycle the counter expires when the FIFO is empty.

Timing and output rules:
- Latency: a push into an empty FIFO with the block idle at edge k gives TX_valid high for the cycle after edge k+1.
- Outputs stay stable from issue until the next issue, even though the serializer latches them.
- Meta bits 5:0 are not checked. Only bit6 selects the spacing.

Boundary conditions:
- A push during WAIT is accepted if not full.
- A push into an empty FIFO in the same cycle that IDLE samples it is not visible until the next edge.
- Spacing counter width is $clog2(DATA_FRAME_CYCLES+GAP_CYCLES+1), with no wrap.
- Reset mid-WAIT or mid-queue: everything clears immediately, and queued packets are lost (the serializer shares rst).

Optional Feature:
- Macro SPI_TX_STATS_EN.
- When defined, adds outputs interest_sent_count[15:0] and data_sent_count[15:0].
  - Each increments on TX_valid according to meta[6].
  - Each wraps 0xFFFF→0 and resets to 0.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single interest push (meta=0x48, prefix=0x0123456789ABCDEF) into an idle block → one TX_valid pulse the cycle after the next edge; outputs match; busy high for 75 cycles; fifo_count returns to 0.
- Three interests pushed back-to-back → three TX_valid pulses exactly 75 cycles apart, in order.
- Data (meta=0x08, data=all 0xA5) followed by an interest → pulses 331 cycles apart; packet_data_input = all 0xA5 on the first pulse.
- Push 5 packets with DEPTH=4 while the first is waiting → in_ready = 0 at count 4, the 5th is held by the source and accepted after the next pop, and no packet is lost or duplicated.
- Assert rst during WAIT with 2 entries queued → TX_valid = 0, fifo_count = 0, busy = 0, outputs = 0; a new push after release issues normally.
- With SPI_TX_STATS_EN: 2 interests and 1 data issued → interest_sent_count = 2, data_sent_count = 1; a counter preloaded to 0xFFFF wraps to 0.
